// File: rtl/note_sequencer_if.sv
// Read-only asynchronous SRAM port shared by the note sequencer (master) and
// the score memory (slave).
interface note_sequencer_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              SRAM_WE;
  logic              SRAM_CE;
  logic              SRAM_OE;
  logic              SRAM_LB;
  logic              SRAM_UB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [15:0]       SRAM_D;

  modport master (
    output SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_A,
    input  SRAM_D
  );
  modport slave (
    input  SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_A,
    output SRAM_D
  );
endinterface

// File: rtl/note_sequencer.sv
// Score player: fetches 16-bit words from SRAM, divides out the tempo on BPM
// words and plays notes as a volume-controlled PWM tone with articulation.
module note_sequencer #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DEFAULT_BPM = 96,
  parameter int unsigned SRAM_WAIT   = 2,
  parameter int unsigned GAP_CYCLES  = CLK_HZ / 50
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  note_sequencer_if.master sram,
  output logic             SPEAKER,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       LED_G,
  output logic [9:0]       LED_R
);

  localparam int unsigned WAIT_W    = $clog2(SRAM_WAIT + 1);
  localparam logic [31:0] DIVIDEND  = 32'(64'(CLK_HZ) * 64'd60);
  localparam logic [31:0] RESET_CPB = 32'((64'(CLK_HZ) * 64'd60) / 64'(DEFAULT_BPM));
  localparam logic [11:0] RESET_BPM = 12'(DEFAULT_BPM);
  localparam logic [37:0] GAP       = 38'(GAP_CYCLES);

  typedef enum logic [2:0] {
    sIdle,
    sFetch,
    sDecode,
    sDiv,
    sPlay,
    sDone
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] sramA;
  logic [WAIT_W-1:0] fetchCnt;
  logic [15:0]       word;
  logic [11:0]       bpm;
  logic [31:0]       cyclesPerBeat;
  logic [31:0]       quot;
  logic [11:0]       rem;
  logic [4:0]        divCnt;
  logic [37:0]       noteLen;
  logic [37:0]       soundLen;
  logic [37:0]       playCnt;
  logic [31:0]       periodReg;
  logic [31:0]       dutyReg;
  logic [31:0]       waveCnt;
  logic [6:0]        ledLow;

  logic [4:0]        decMult;
  logic [39:0]       decProd;
  logic [37:0]       decLen;
  logic              decRest;
  logic [31:0]       decPeriod;
  logic [31:0]       decDuty;
  logic [37:0]       decSound;
  logic [9:0]        decLedR;
  logic [12:0]       remShift;
  logic              divFits;
  logic [11:0]       remNext;
  logic [31:0]       quotNext;
  logic [37:0]       playNext;
  logic [31:0]       waveNext;

  // Octave-3 periods in clock cycles, rounded; frequencies in millihertz.
  function automatic logic [31:0] cyc(input longint unsigned fmHz);
    return 32'((64'(CLK_HZ) * 64'd1000 + fmHz / 64'd2) / fmHz);
  endfunction

  function automatic logic [31:0] periodOf(input logic [3:0] n);
    logic [31:0] p;
    case (n)
      4'd0:    p = cyc(130813);
      4'd1:    p = cyc(138591);
      4'd2:    p = cyc(146832);
      4'd3:    p = cyc(155563);
      4'd4:    p = cyc(164814);
      4'd5:    p = cyc(174614);
      4'd6:    p = cyc(184997);
      4'd7:    p = cyc(195998);
      4'd8:    p = cyc(207652);
      4'd9:    p = cyc(220000);
      4'd10:   p = cyc(233082);
      default: p = cyc(246942);
    endcase
    return p;
  endfunction

  assign sram.SRAM_WE = 1'b1;
  assign sram.SRAM_CE = 1'b0;
  assign sram.SRAM_OE = 1'b0;
  assign sram.SRAM_LB = 1'b0;
  assign sram.SRAM_UB = 1'b0;
  assign sram.SRAM_A  = sramA;
  assign LED_G        = {BUSY, ledLow};

  always_comb begin
    case (word[11:8])
      4'd0:    decMult = 5'd16;
      4'd1:    decMult = 5'd8;
      4'd2:    decMult = 5'd4;
      4'd3:    decMult = 5'd2;
      4'd4:    decMult = 5'd1;
      4'd5:    decMult = 5'd12;
      4'd6:    decMult = 5'd6;
      4'd7:    decMult = 5'd3;
      default: decMult = 5'd4;
    endcase
    decProd = 40'(cyclesPerBeat) * 40'(decMult);
    decLen  = 38'(decProd >> 2);
    if (decLen == '0) decLen = 38'd1;

    decRest   = word[3:0] >= 4'd12;
    decPeriod = periodOf(word[3:0]) >> word[5:4];
    decDuty   = 32'((35'(decPeriod) * 35'(word[7:6]) + 35'(decPeriod)) >> 3);
    decLedR   = decRest ? '0 : 10'(word[5:4]) * 10'd12 + 10'(word[3:0]);

    case (word[13:12])
      2'd1:    decSound = decLen;
      2'd2:    decSound = decLen >> 1;
      default: decSound = (decLen > GAP) ? decLen - GAP : '0;
    endcase
    if (decRest) decSound = '0;

    // One restoring-division step; the remainder stays below bpm, so 12 bits hold it.
    remShift = {rem, quot[31]};
    divFits  = remShift >= {1'b0, bpm};
    remNext  = divFits ? 12'(remShift - {1'b0, bpm}) : remShift[11:0];
    quotNext = {quot[30:0], divFits};

    playNext = playCnt + 38'd1;
    waveNext = (waveCnt == periodReg - 32'd1) ? '0 : waveCnt + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= sIdle;
      pc            <= '0;
      sramA         <= '0;
      fetchCnt      <= '0;
      word          <= '0;
      bpm           <= RESET_BPM;
      cyclesPerBeat <= RESET_CPB;
      quot          <= '0;
      rem           <= '0;
      divCnt        <= '0;
      noteLen       <= '0;
      soundLen      <= '0;
      playCnt       <= '0;
      periodReg     <= '0;
      dutyReg       <= '0;
      waveCnt       <= '0;
      ledLow        <= '0;
      LED_R         <= '0;
      SPEAKER       <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      case (state)
        sIdle, sDone: begin
          if (START) begin
            state         <= sFetch;
            pc            <= '0;
            sramA         <= '0;
            fetchCnt      <= '0;
            bpm           <= RESET_BPM;
            cyclesPerBeat <= RESET_CPB;
            BUSY          <= 1'b1;
            DONE          <= 1'b0;
          end
        end

        // First cycle presents the address; data is captured SRAM_WAIT edges later.
        sFetch: begin
          if (fetchCnt == '0) sramA <= pc;
          if (fetchCnt == WAIT_W'(SRAM_WAIT)) begin
            word     <= sram.SRAM_D;
            pc       <= pc + ADDR_W'(1);
            fetchCnt <= '0;
            state    <= sDecode;
          end else begin
            fetchCnt <= fetchCnt + WAIT_W'(1);
          end
        end

        sDecode: begin
          if (word[15]) begin
            state     <= sPlay;
            noteLen   <= decLen;
            soundLen  <= decSound;
            periodReg <= decPeriod;
            dutyReg   <= decDuty;
            playCnt   <= '0;
            waveCnt   <= '0;
            SPEAKER   <= (decSound != '0) && (decDuty != '0);
            ledLow    <= {decRest, word[5:0]};
            LED_R     <= decLedR;
          end else if (word[14:12] == 3'b000) begin
            state <= sDone;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (word[14:12] == 3'b001 && word[11:0] != '0) begin
            state  <= sDiv;
            bpm    <= word[11:0];
            quot   <= DIVIDEND;
            rem    <= '0;
            divCnt <= '0;
          end else begin
            state <= sFetch;
          end
        end

        sDiv: begin
          quot   <= quotNext;
          rem    <= remNext;
          divCnt <= divCnt + 5'd1;
          if (divCnt == 5'd31) begin
            cyclesPerBeat <= quotNext;
            state         <= sFetch;
          end
        end

        // SPEAKER is registered, so each edge computes the level for the next cycle.
        sPlay: begin
          if (playCnt == noteLen - 38'd1) begin
            state   <= sFetch;
            SPEAKER <= 1'b0;
          end else begin
            playCnt <= playNext;
            waveCnt <= waveNext;
            SPEAKER <= (playNext < soundLen) && (waveNext < dutyReg);
          end
        end

        default: state <= sIdle;
      endcase
    end
  end

endmodule
